// File: rtl/game_pkg.sv
// Shared types and sizes for the brick-game play controller.
package game_pkg;

    localparam int unsigned BRICK_COUNT = 56;
    localparam int unsigned BRICK_CNT_W = 6;
    localparam int unsigned ROW_W       = 3;
    localparam int unsigned COL_W       = 3;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned LEVEL_W     = 4;
    localparam int unsigned STATE_W     = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_SERVE     = 4'd1,
        ST_WAIT_TICK = 4'd2,
        ST_STEP      = 4'd3,
        ST_HIT       = 4'd4,
        ST_CHECK     = 4'd5,
        ST_LOST      = 4'd6,
        ST_CLEAR     = 4'd7,
        ST_OVER      = 4'd8
    } state_e;

    // Saturating level increment.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == {LEVEL_W{1'b1}}) ? lvl : lvl + LEVEL_W'(1);
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider: counts while enabled, period shrinks by 2x per level up to level 3.
module game_tick_gen
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en_i,
    input  logic               reload_i,
    input  logic [LEVEL_W-1:0] level_i,
    output logic               tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'((TICK_DIV >> 1) - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'((TICK_DIV >> 2) - 1);
    localparam logic [CNT_W-1:0] LAST3 = CNT_W'((TICK_DIV >> 3) - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_c;

    // Terminal count for the current level.
    always_comb begin
        last_c = LAST3;
        if (level_i < LEVEL_W'(3)) begin
            case (level_i[1:0])
                2'd0:    last_c = LAST0;
                2'd1:    last_c = LAST1;
                default: last_c = LAST2;
            endcase
        end
    end

    assign tick_c = en_i && (cnt_q == last_c);

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Brick-game play controller: tick-paced step/hit/check loop with lives, level and handshake timeouts.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 25_000_000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_btn,
    input  logic [BRICK_CNT_W-1:0] bricks_left,
    input  logic                   ball_missed,
    input  logic                   step_done,
    input  logic                   hit_done,
    output logic                   step_req,
    output logic                   hit_req,
    output logic                   serve,
    output logic                   bricks_reload,
    output logic                   score_clear,
    output logic [LIVES_W-1:0]     lives,
    output logic [LEVEL_W-1:0]     level,
    output logic [STATE_W-1:0]     state_o,
    output logic                   fault
);

    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_e              state_q,         state_d;
    logic [LIVES_W-1:0]  lives_q,         lives_d;
    logic [LEVEL_W-1:0]  level_q,         level_d;
    logic [WAIT_W-1:0]   wait_q,          wait_d;
    logic                miss_q,          miss_d;
    logic                fault_q,         fault_d;
    logic                step_req_q,      step_req_d;
    logic                hit_req_q,       hit_req_d;
    logic                serve_q,         serve_d;
    logic                bricks_reload_q, bricks_reload_d;
    logic                score_clear_q,   score_clear_d;
    logic                tick_c;

    game_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .en_i     (state_q == ST_WAIT_TICK),
        .reload_i (state_q != ST_WAIT_TICK),
        .level_i  (level_q),
        .tick_c   (tick_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            lives_q         <= LIVES_INIT;
            level_q         <= '0;
            wait_q          <= '0;
            miss_q          <= 1'b0;
            fault_q         <= 1'b0;
            step_req_q      <= 1'b0;
            hit_req_q       <= 1'b0;
            serve_q         <= 1'b0;
            bricks_reload_q <= 1'b0;
            score_clear_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            level_q         <= level_d;
            wait_q          <= wait_d;
            miss_q          <= miss_d;
            fault_q         <= fault_d;
            step_req_q      <= step_req_d;
            hit_req_q       <= hit_req_d;
            serve_q         <= serve_d;
            bricks_reload_q <= bricks_reload_d;
            score_clear_q   <= score_clear_d;
        end
    end

    // Requests hold their value; pulses default low so they last exactly one cycle.
    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        level_d         = level_q;
        wait_d          = wait_q;
        miss_d          = miss_q;
        fault_d         = fault_q;
        step_req_d      = step_req_q;
        hit_req_d       = hit_req_q;
        serve_d         = 1'b0;
        bricks_reload_d = 1'b0;
        score_clear_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_btn) begin
                    score_clear_d   = 1'b1;
                    bricks_reload_d = 1'b1;
                    lives_d         = LIVES_INIT;
                    level_d         = '0;
                    state_d         = ST_SERVE;
                end
            end
            ST_SERVE: begin
                serve_d = 1'b1;
                state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (tick_c) begin
                    step_req_d = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_STEP;
                end
            end
            ST_STEP: begin
                if (step_req_q && step_done) begin
                    miss_d     = ball_missed;
                    step_req_d = 1'b0;
                    hit_req_d  = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_HIT;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d    = 1'b1;
                    miss_d     = 1'b0;
                    step_req_d = 1'b0;
                    hit_req_d  = 1'b1;
                    wait_d     = '0;
                    state_d    = ST_HIT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_HIT: begin
                if ((hit_req_q && hit_done) || (wait_q == WAIT_LAST)) begin
                    if (!(hit_req_q && hit_done)) begin
                        fault_d = 1'b1;
                    end
                    hit_req_d = 1'b0;
                    wait_d    = '0;
                    state_d   = ST_CHECK;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CHECK: begin
                if (bricks_left == '0) begin
                    state_d = ST_CLEAR;
                end else if (miss_q) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_LOST: begin
                if (lives_q <= LIVES_W'(1)) begin
                    lives_d = '0;
                    state_d = ST_OVER;
                end else begin
                    lives_d = lives_q - LIVES_W'(1);
                    state_d = ST_SERVE;
                end
            end
            ST_CLEAR: begin
                level_d         = level_inc(level_q);
                bricks_reload_d = 1'b1;
                state_d         = ST_SERVE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign step_req      = step_req_q;
    assign hit_req       = hit_req_q;
    assign serve         = serve_q;
    assign bricks_reload = bricks_reload_q;
    assign score_clear   = score_clear_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign state_o       = state_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a 16-cycle tick divider.
module tb_game_sequencer;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SERVE = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_STEP  = 4'd3;
    localparam logic [3:0] S_HIT   = 4'd4;
    localparam logic [3:0] S_CHECK = 4'd5;
    localparam logic [3:0] S_LOST  = 4'd6;
    localparam logic [3:0] S_CLEAR = 4'd7;
    localparam logic [3:0] S_OVER  = 4'd8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic [5:0] bricks_left = 6'd40;
    logic       ball_missed = 1'b0;
    logic       step_done = 1'b0;
    logic       hit_done = 1'b0;
    logic       step_req, hit_req, serve, bricks_reload, score_clear, fault;
    logic [1:0] lives;
    logic [3:0] level;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .TICK_DIV    (16),
        .LIVES       (3),
        .ACK_TIMEOUT (15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_btn     (start_btn),
        .bricks_left   (bricks_left),
        .ball_missed   (ball_missed),
        .step_done     (step_done),
        .hit_done      (hit_done),
        .step_req      (step_req),
        .hit_req       (hit_req),
        .serve         (serve),
        .bricks_reload (bricks_reload),
        .score_clear   (score_clear),
        .lives         (lives),
        .level         (level),
        .state_o       (state_o),
        .fault         (fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("wait_state", 32'(state_o), 32'(s));
    endtask

    // One tick round: step_done with the given miss, then hit_done; ends with state CHECK.
    task automatic run_round(input logic miss, input logic [5:0] bl);
        bricks_left = bl;
        wait_state(S_STEP, 100);
        step_done = 1'b1;
        ball_missed = miss;
        cyc(1);
        step_done = 1'b0;
        ball_missed = 1'b0;
        chk("round_hit", 32'(state_o), 32'(S_HIT));
        hit_done = 1'b1;
        cyc(1);
        hit_done = 1'b0;
        chk("round_check", 32'(state_o), 32'(S_CHECK));
    endtask

    task automatic lose_life(input logic [1:0] exp_lives, input logic [3:0] exp_state);
        run_round(1'b1, 6'd40);
        cyc(1);
        chk("lost_state", 32'(state_o), 32'(S_LOST));
        cyc(1);
        chk("lost_next", 32'(state_o), 32'(exp_state));
        chk("lost_lives", 32'(lives), 32'(exp_lives));
    endtask

    initial begin
        logic seen;

        // 1: reset, start, serve and first tick
        cyc(1);
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_outs", 32'({step_req, hit_req, serve, bricks_reload, score_clear, fault}), 32'd0);
        reset = 1'b1;
        cyc(1);
        chk("idle_hold", 32'(state_o), 32'(S_IDLE));
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        chk("start_pulses", 32'({score_clear, bricks_reload, serve}), 32'b110);
        chk("start_state", 32'(state_o), 32'(S_SERVE));
        cyc(1);
        chk("serve_pulse", 32'({score_clear, bricks_reload, serve}), 32'b001);
        chk("serve_state", 32'(state_o), 32'(S_WAIT));
        cyc(15);
        chk("tick_not_yet", 32'({step_req, state_o}), 32'({1'b0, S_WAIT}));
        cyc(1);
        chk("tick_step", 32'({step_req, state_o}), 32'({1'b1, S_STEP}));

        // 2: normal round, no miss
        cyc(2);
        step_done = 1'b1;
        cyc(1);
        step_done = 1'b0;
        chk("step_ack", 32'({step_req, hit_req}), 32'b01);
        cyc(1);
        hit_done = 1'b1;
        cyc(1);
        hit_done = 1'b0;
        chk("hit_ack", 32'({hit_req, state_o}), 32'({1'b0, S_CHECK}));
        cyc(1);
        chk("back_wait", 32'(state_o), 32'(S_WAIT));
        chk("round_lives_fault", 32'({lives, fault}), 32'({2'd3, 1'b0}));

        // 3: three misses to game over, then new game
        lose_life(2'd2, S_SERVE);
        lose_life(2'd1, S_SERVE);
        lose_life(2'd0, S_OVER);
        cyc(5);
        chk("over_hold", 32'(state_o), 32'(S_OVER));
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        chk("new_game", 32'({lives, level, state_o}), 32'({2'd3, 4'd0, S_SERVE}));
        chk("new_game_pulses", 32'({score_clear, bricks_reload}), 32'b11);

        // 4: clear beats miss, level 1 halves the period
        run_round(1'b1, 6'd0);
        cyc(1);
        chk("clear_state", 32'(state_o), 32'(S_CLEAR));
        cyc(1);
        chk("clear_next", 32'({state_o, level, lives}), 32'({S_SERVE, 4'd1, 2'd3}));
        chk("clear_reload", 32'({bricks_reload, score_clear}), 32'b10);
        bricks_left = 6'd40;
        cyc(1);
        chk("clear_serve", 32'({serve, state_o}), 32'({1'b1, S_WAIT}));
        cyc(7);
        chk("l1_not_yet", 32'(state_o), 32'(S_WAIT));
        cyc(1);
        chk("l1_tick", 32'(state_o), 32'(S_STEP));

        // 5: step timeout sets fault; miss input ignored on timeout
        ball_missed = 1'b1;
        cyc(14);
        chk("to_pending", 32'({fault, state_o}), 32'({1'b0, S_STEP}));
        cyc(1);
        chk("to_fault", 32'({fault, state_o}), 32'({1'b1, S_HIT}));
        chk("to_reqs", 32'({step_req, hit_req}), 32'b01);
        ball_missed = 1'b0;
        hit_done = 1'b1;
        cyc(1);
        hit_done = 1'b0;
        cyc(1);
        chk("to_no_miss", 32'({state_o, lives}), 32'({S_WAIT, 2'd3}));
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        chk("start_ignored", 32'({state_o, score_clear}), 32'({S_WAIT, 1'b0}));
        lose_life(2'd2, S_SERVE);
        lose_life(2'd1, S_SERVE);
        lose_life(2'd0, S_OVER);
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        chk("fault_sticky", 32'({fault, lives, level}), 32'({1'b1, 2'd3, 4'd0}));

        // 6: async reset during hit handshake
        wait_state(S_STEP, 100);
        step_done = 1'b1;
        cyc(1);
        step_done = 1'b0;
        chk("pre_rst_hit", 32'(hit_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", 32'({hit_req, step_req, state_o}), 32'({2'b00, S_IDLE}));
        cyc(1);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen |= score_clear | bricks_reload | serve | step_req | hit_req;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);
        chk("post_rst_state", 32'({state_o, fault, lives}), 32'({S_IDLE, 1'b0, 2'd3}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
